gc_vec_src: RTL and testbench

Sequenced stimulus source for the GC datapath. On a start request it latches one of eight built-in operand patterns, chosen by `sw_in`, and streams them out as a frame of `NCH`-lane beats over a valid/ready handshake. Each frame carries two input groups and three weight groups, each `DEPTH` rows deep. Alongside the frame it holds the scalar parameters (`lunda`, `gama`, `beta`) and the mux-select word for the downstream compute array.

---
 rtl/gc_vec_src.sv | 186 ++++++++++++++++++
 tb/tb_gc_vec_src.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gc_vec_src.sv
// gc_vec_src -- sequenced stimulus source for the GC datapath.
//
// On an accepted start it latches one of eight built-in operand patterns
// (chosen by sw_in). It then streams a frame of NCH-lane beats over a
// valid/ready handshake. The frame is five groups (I0, I1, W0, W1, W2) of
// DEPTH rows each, sent grp-major and row-minor. It also drives the frame's
// scalar parameters and the mux-select word for the compute array.
//
// Optional feature macro: GC_VEC_RAMP_EN
//   defined   : lane k of row r = (base + r*NCH + k) mod 2^N
//   undefined : every lane = base (no ramp adder is built)
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   sw_in      in   [2:0] pattern select, sampled only when start is accepted
//   start      in   frame request, honoured only in IDLE
//   out_valid  out  beat valid
//   out_ready  in   consumer ready
//   out_data   out  [NCH*N-1:0] lane k at bits [k*N +: N]
//   out_grp    out  [2:0] 0=I0 1=I1 2=W0 3=W1 4=W2
//   out_row    out  [RW-1:0] row within group
//   out_last   out  final beat of the frame
//   busy       out  frame in progress (STREAM or DONE)
//   done       out  one-cycle pulse after the last beat transfers
//   lunda/gama/beta out [2N-1:0] frame parameters
//   sel        out  [5:0] {select_m0..m3, select0, select1}
module gc_vec_src #(
  parameter int N     = 8,
  parameter int NCH   = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 sw_in,
  input  logic                       start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NCH*N-1:0]           out_data,
  output logic [2:0]                 out_grp,
  output logic [$clog2(DEPTH)-1:0]   out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [2*N-1:0]             lunda,
  output logic [2*N-1:0]             gama,
  output logic [2*N-1:0]             beta,
  output logic [5:0]                 sel
);

  localparam int RW = $clog2(DEPTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t      state_reg;
  logic [2:0]  pat_reg;

  // Base value of group grp in pattern pat.
  function automatic logic [2:0] base_of(input logic [2:0] pat, input logic [2:0] grp);
    logic [14:0] tbl;
    tbl = '0;
    case (pat)
      3'd0: tbl = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      3'd1: tbl = {3'd2, 3'd1, 3'd4, 3'd3, 3'd2};
      3'd2: tbl = {3'd3, 3'd4, 3'd2, 3'd5, 3'd1};
      3'd3: tbl = {3'd4, 3'd1, 3'd5, 3'd2, 3'd3};
      3'd4: tbl = {3'd2, 3'd5, 3'd4, 3'd3, 3'd1};
      3'd5: tbl = {3'd3, 3'd2, 3'd1, 3'd5, 3'd4};
      3'd6: tbl = {3'd5, 3'd1, 3'd2, 3'd4, 3'd3};
      3'd7: tbl = {3'd3, 3'd5, 3'd4, 3'd1, 3'd2};
      default: tbl = '0;
    endcase
    case (grp)
      3'd0:    return tbl[14:12];
      3'd1:    return tbl[11:9];
      3'd2:    return tbl[8:6];
      3'd3:    return tbl[5:3];
      default: return tbl[2:0];
    endcase
  endfunction

  // Position of the beat that will be loaded at the next edge: the first
  // beat when leaving IDLE, otherwise the successor of the current beat.
  logic [2:0]        load_pat;
  logic [2:0]        load_grp;
  logic [RW-1:0]     load_row;
  logic              last_next;
  logic [2:0]        base_next;
  logic [NCH*N-1:0]  data_next;

  always_comb begin
    load_pat = pat_reg;
    load_grp = out_grp;
    load_row = out_row;
    if (state_reg == ST_IDLE) begin
      load_pat = sw_in;
      load_grp = 3'd0;
      load_row = '0;
    end else if (out_row == ROW_MAX) begin
      load_grp = out_grp + 3'd1;
      load_row = '0;
    end else begin
      load_row = out_row + RW'(1);
    end
    last_next = (load_grp == 3'd4) && (load_row == ROW_MAX);
    base_next = base_of(load_pat, load_grp);
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
`ifdef GC_VEC_RAMP_EN
      // Truncation to N bits provides the mod 2^N wrap.
      assign data_next[gi*N +: N] = N'(base_next) + N'(32'(load_row) * NCH) + N'(gi);
`else
      assign data_next[gi*N +: N] = N'(base_next);
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pat_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grp   <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lunda     <= '0;
      gama      <= '0;
      beta      <= '0;
      sel       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg <= ST_STREAM;
            pat_reg   <= sw_in;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_grp   <= load_grp;
            out_row   <= load_row;
            out_data  <= data_next;
            out_last  <= last_next;
            lunda     <= (2*N)'(2);
            gama      <= (2*N)'(3);
            beta      <= (2*N)'(4);
            sel       <= 6'b000010;
          end
        end
        ST_STREAM: begin
          // out_valid is always high here, so a transfer is just out_ready.
          if (out_ready) begin
            if (out_last) begin
              state_reg <= ST_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_grp  <= load_grp;
              out_row  <= load_row;
              out_data <= data_next;
              out_last <= last_next;
            end
          end
        end
        ST_DONE: begin
          // start is ignored here; a new frame can begin from the next IDLE cycle.
          state_reg <= ST_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_vec_src.sv
// Testbench for gc_vec_src: directed frames with random pattern selection and
// random backpressure, checked against a table-driven frame model.
module tb_gc_vec_src;

  localparam int N     = 8;
  localparam int NCH   = 8;
  localparam int DEPTH = 4;
  localparam int RW    = $clog2(DEPTH);
  localparam int BEATS = 5 * DEPTH;
  localparam int DW    = N * NCH;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      sw_in = '0;
  logic            start = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_grp;
  logic [RW-1:0]   out_row;
  logic            out_last;
  logic            busy;
  logic            done;
  logic [2*N-1:0]  lunda;
  logic [2*N-1:0]  gama;
  logic [2*N-1:0]  beta;
  logic [5:0]      sel;

  int checks = 0;
  int failures = 0;

  // Base values (I0, I1, W0, W1, W2) for each pattern.
  int tbl [8][5] = '{
    '{1, 2, 3, 4, 5}, '{2, 1, 4, 3, 2}, '{3, 4, 2, 5, 1}, '{4, 1, 5, 2, 3},
    '{2, 5, 4, 3, 1}, '{3, 2, 1, 5, 4}, '{5, 1, 2, 4, 3}, '{3, 5, 4, 1, 2}
  };

  gc_vec_src #(.N(N), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_grp(out_grp), .out_row(out_row), .out_last(out_last),
    .busy(busy), .done(done), .lunda(lunda), .gama(gama), .beta(beta),
    .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beat payload for beat index idx of pattern pat.
  function automatic logic [DW-1:0] exp_data(input int pat, input int idx);
    logic [DW-1:0] d;
    int g, r, v;
    g = idx / DEPTH;
    r = idx % DEPTH;
    d = '0;
    for (int k = 0; k < NCH; k++) begin
      v = tbl[pat][g];
`ifdef GC_VEC_RAMP_EN
      v = v + r * NCH + k;
`endif
      v = v % (1 << N);
      d[k*N +: N] = v[N-1:0];
    end
    return d;
  endfunction

  task automatic chk_beat(input int pat, input int idx);
    chk("valid", 128'(out_valid), 128'(1));
    chk("busy", 128'(busy), 128'(1));
    chk("done_mid", 128'(done), 128'(0));
    chk("data", 128'(out_data), 128'(exp_data(pat, idx)));
    chk("grp", 128'(out_grp), 128'(idx / DEPTH));
    chk("row", 128'(out_row), 128'(idx % DEPTH));
    chk("last", 128'(out_last), 128'(idx == BEATS - 1));
  endtask

  task automatic chk_params();
    chk("lunda", 128'(lunda), 128'(2));
    chk("gama", 128'(gama), 128'(3));
    chk("beta", 128'(beta), 128'(4));
    chk("sel", 128'(sel), 128'(6'b000010));
  endtask

  task automatic chk_reset_vals(input string tag);
    $display("step: reset values (%s)", tag);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_grp", 128'(out_grp), 128'(0));
    chk("rst_row", 128'(out_row), 128'(0));
    chk("rst_lunda", 128'(lunda), 128'(0));
    chk("rst_gama", 128'(gama), 128'(0));
    chk("rst_beta", 128'(beta), 128'(0));
    chk("rst_sel", 128'(sel), 128'(0));
  endtask

  // One complete frame. Called and returns at a negedge with the DUT in IDLE.
  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at beat 5.
  task automatic run_frame(input int pat, input int mode, input bit mid_start);
    int idx = 0, cyc = 0, stalls = 0, hold = 0, exp_cyc;
    bit rdy;
    sw_in = 3'(pat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sw_in = 3'($urandom_range(0, 7));
    while (idx < BEATS && cyc < 500) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (idx == 5 && hold < 3) begin rdy = 1'b0; hold++; end
          else rdy = 1'b1;
        end
      endcase
      out_ready = rdy;
      if (mid_start && idx == 7) begin start = 1'b1; sw_in = 3'd7; end
      else start = 1'b0;
      chk_beat(pat, idx);
      if (rdy) idx++;
      else stalls++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    exp_cyc = (mode == 2) ? BEATS + 3 : BEATS + stalls;
    chk("frame_cycles", 128'(cyc), 128'(exp_cyc));
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_valid", 128'(out_valid), 128'(0));
    chk("done_busy", 128'(busy), 128'(1));
    chk_params();
    // start during the DONE cycle must be ignored
    start = 1'b1;
    sw_in = 3'($urandom_range(0, 7));
    @(negedge clk);
    start = 1'b0;
    chk("done_once", 128'(done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("no_restart", 128'(out_valid), 128'(0));
    chk_params();
    $display("frame: pat=%0d mode=%0d mid_start=%0d cycles=%0d stalls=%0d", pat, mode, mid_start, cyc, stalls);
  endtask

  // Reset asserted while beat 10 is on the bus.
  task automatic reset_mid_frame(input int pat);
    sw_in = 3'(pat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_beat(pat, i);
      @(negedge clk);
    end
    chk_beat(pat, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("mid-frame");
    @(negedge clk);
    chk("post_rst_done", 128'(done), 128'(0));
    chk("post_rst_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("power-up");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", 128'(out_valid), 128'(0));

    run_frame(0, 0, 1'b0);                      // flat frame, ready high
    run_frame(3, 2, 1'b0);                      // 3-cycle backpressure at beat 5
    run_frame(6, 1, 1'b1);                      // ignored mid-frame start/sw_in
    reset_mid_frame(int'($urandom_range(0, 7)));
    run_frame(2, 0, 1'b0);                      // first beat after reset: lanes = 3
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(0, 7)), 1, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
